// File: rtl/pool_pkg.sv
// Shared types and the quantizer used by the pooled-output writer.
package pool_pkg;

    localparam int OUT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Optional ReLU, arithmetic right shift, then clamp to a signed out_width range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] v,
        input int                 shift,
        input int                 out_width,
        input bit                 relu
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (relu && (v < 0)) ? 64'sd0 : v;
        r  = r >>> shift;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; push and pop may happen in the same cycle, even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pool_ofm_writer.sv
// Quantizes the pooled stream and writes it, channel-major, into the OFM buffer through a small FIFO.
module pool_ofm_writer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = pool_pkg::OUT_WIDTH,
    parameter int OFM_SIZE   = 23,
    parameter int CI         = 3,
    parameter int SHIFT      = 8,
    parameter int RELU       = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(CI * OFM_SIZE * OFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [OUT_WIDTH-1:0]  mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int                  TOTAL   = CI * OFM_SIZE * OFM_SIZE;
    localparam logic [ADDR_WIDTH:0] TOTAL_C = (ADDR_WIDTH+1)'(TOTAL);
    localparam int                  FW      = ADDR_WIDTH + OUT_WIDTH;

    state_t                state;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  accept;
    logic [OUT_WIDTH-1:0]  q_word;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [OUT_WIDTH-1:0]  s1_word;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_head;
    logic                  drop;

    logic [ADDR_WIDTH-1:0] last_addr;
    logic [OUT_WIDTH-1:0]  last_word;

    // The counter stops at TOTAL, so no out-of-frame address can ever be tagged.
    assign accept = in_valid && (state == RUN) && (cnt != TOTAL_C);
    assign q_word = OUT_WIDTH'(sat_shift(64'(signed'(data_in)), SHIFT, OUT_WIDTH, RELU != 0));

    assign mem_we    = !fifo_empty;
    assign fifo_pop  = mem_we && mem_ready;
    assign fifo_push = s1_valid && (!fifo_full || fifo_pop);
    assign drop      = s1_valid && fifo_full && !fifo_pop;

    // With nothing queued the bus keeps showing the last word written.
    assign mem_addr  = fifo_empty ? last_addr : fifo_head[FW-1:OUT_WIDTH];
    assign mem_wdata = fifo_empty ? last_word : fifo_head[OUT_WIDTH-1:0];

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({s1_addr, s1_word}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) cnt <= cnt + 1'b1;
            if (drop)   overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == TOTAL_C) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && !s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_word   <= '0;
            last_addr <= '0;
            last_word <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= cnt[ADDR_WIDTH-1:0];
                s1_word <= q_word;
            end
            if (fifo_pop) begin
                last_addr <= fifo_head[FW-1:OUT_WIDTH];
                last_word <= fifo_head[OUT_WIDTH-1:0];
            end
        end
    end

endmodule
